eth_latency_timer: RTL and testbench
====================================

ETH_LATENCY_TIMER -- requirements
Module: eth_latency_timer

Interface
REQ-001 Parameter TIMER_WIDTH, default 32, width of timer and each latency field; legal 8..62.
REQ-002 Parameter FIFO_DEPTH, default 16, record capacity; power of two, 2..1024.
REQ-003 Parameter OVERFLOW_MODE, default 0, full-FIFO policy: 0 = drop oldest, 1 = drop newest.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 main_tx_begin  input  1  main port started a probe frame.
REQ-007 main_rx_end  input  1  main port received the returned frame.
REQ-008 main_rx_timeout  input  1  main port gave up waiting.
REQ-009 loop_tx_begin  input  1  loop port started a frame.
REQ-010 loop_rx_end  input  1  loop port received the probe.
REQ-011 loop_rx_timeout  input  1  loop port gave up waiting.
REQ-012 fifo_read  input  1  pop head record.
REQ-013 fifo_out  output  2*TIMER_WIDTH  head record, {pong, ping}, ping in low half.
REQ-014 fifo_empty  output  1  no record held.
REQ-015 fifo_level  output  $clog2(FIFO_DEPTH+1)  records held.
REQ-016 drop_count  output  32  records lost to overflow (present only with REQ-036 macro).

Function
REQ-017 FSM states: IDLE, WAIT_LOOP, WAIT_MAIN.
- REQ-018 Event priority per cycle, highest first: tx_begin (main or loop), loop_rx_end, loop_rx_timeout, main_rx_end, main_rx_timeout; at most one acted on.
- REQ-019 Any state, tx_begin: timer <= 2, ping <= 0, pong <= 0, state <= WAIT_LOOP; measurement in progress abandoned, no record.
- REQ-020 WAIT_LOOP, loop_rx_end: ping <= timer, state <= WAIT_MAIN.
- REQ-021 WAIT_LOOP, loop_rx_timeout: ping and pong <= all-ones, record written, state <= IDLE.
- REQ-022 WAIT_MAIN, main_rx_end: pong <= timer, record written, state <= IDLE.
- REQ-023 WAIT_MAIN, main_rx_timeout: pong <= all-ones (ping kept), record written, state <= IDLE.
- REQ-024 Events not listed for the current state are ignored, no side effects (e.g. main_rx_end in IDLE or WAIT_LOOP).
- REQ-025 Timer increments by 1 every cycle without tx_begin; saturates at 2^TIMER_WIDTH-2; all-ones is reserved as the timeout marker and never a measured value.
- REQ-026 Record latency: event sampled at edge k -> record at fifo_out and fifo_empty low after edge k+1 when FIFO was empty.
- REQ-027 FIFO is first-word-fall-through; fifo_out valid whenever fifo_empty is low; fifo_out undefined-but-stable when empty.
- REQ-028 fifo_read with fifo_empty low pops at that edge; fifo_read while empty ignored.
- REQ-029 Simultaneous write and pop: both done, level unchanged, never a drop even when full.
- REQ-030 Write when full, no pop, OVERFLOW_MODE 0: oldest discarded, new stored, level stays FIFO_DEPTH.
- REQ-031 Write when full, no pop, OVERFLOW_MODE 1: new record discarded, contents unchanged.
- REQ-032 Pointers wrap modulo FIFO_DEPTH; fifo_level never exceeds FIFO_DEPTH.

Reset
REQ-033 rst_n low asynchronously: state IDLE, timer 0, ping 0, pong 0, pending write cleared, FIFO emptied, fifo_level 0, fifo_empty 1, drop_count 0.
REQ-034 While rst_n low all inputs ignored; reset mid-measurement discards it, no record.
REQ-035 First event acted on is the one sampled at the first rising edge after rst_n deasserts.

Configuration
REQ-036 Macro ETH_LATENCY_TIMER_DROP_COUNT_EN defined: drop_count port present, increments by 1 per REQ-030/REQ-031 drop, saturates at 0xFFFFFFFF, cleared only by reset.
REQ-037 Macro undefined: drop_count port and counter absent; all other behaviour identical.

Verification
REQ-038 Defaults; main_tx_begin @0, loop_rx_end @10, main_rx_end @25 -> one record, ping=11, pong=26, fifo_empty low after edge 26.
REQ-039 main_tx_begin @0, loop_rx_timeout @5 -> record 0xFFFFFFFF_FFFFFFFF; later main_rx_end in IDLE -> no record.
REQ-040 TIMER_WIDTH=8; main_tx_begin, wait 300 cycles, loop_rx_end, main_rx_end -> ping=0xFE, pong=0xFE.
REQ-041 FIFO_DEPTH=4, OVERFLOW_MODE=0, 6 records, no reads -> level 4, records 3..6 read in order, drop_count=2 (macro on); OVERFLOW_MODE=1 -> records 1..4, drop_count=2.
REQ-042 FIFO full, write and fifo_read same cycle -> level stays 4, no drop; rst_n pulsed low mid WAIT_MAIN -> level 0, no record on subsequent main_rx_end.

Source files
------------

// File: rtl/eth_latency_timer_if.sv
// eth_latency_timer_if: probe event inputs, record FIFO read side and FSM debug view.
// Optional feature: ETH_LATENCY_TIMER_DROP_COUNT_EN adds the drop_count output.
// Handshake: fifo_empty low means fifo_out holds a valid head record; asserting
// fifo_read while fifo_empty is low consumes that record at the rising edge.
// A fifo_read while fifo_empty is high has no effect.
interface eth_latency_timer_if #(
  parameter int TIMER_WIDTH = 32,
  parameter int FIFO_DEPTH  = 16
);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH + 1);

  logic                     main_tx_begin;
  logic                     main_rx_end;
  logic                     main_rx_timeout;
  logic                     loop_tx_begin;
  logic                     loop_rx_end;
  logic                     loop_rx_timeout;
  logic                     fifo_read;
  logic [2*TIMER_WIDTH-1:0] fifo_out;
  logic                     fifo_empty;
  logic [LEVEL_W-1:0]       fifo_level;
  logic [1:0]               fsm_state;
`ifdef ETH_LATENCY_TIMER_DROP_COUNT_EN
  logic [31:0]              drop_count;
`endif

  modport master (
    output main_tx_begin, main_rx_end, main_rx_timeout,
    output loop_tx_begin, loop_rx_end, loop_rx_timeout, fifo_read,
    input  fifo_out, fifo_empty, fifo_level, fsm_state
`ifdef ETH_LATENCY_TIMER_DROP_COUNT_EN
    , input drop_count
`endif
  );

  modport slave (
    input  main_tx_begin, main_rx_end, main_rx_timeout,
    input  loop_tx_begin, loop_rx_end, loop_rx_timeout, fifo_read,
    output fifo_out, fifo_empty, fifo_level, fsm_state
`ifdef ETH_LATENCY_TIMER_DROP_COUNT_EN
    , output drop_count
`endif
  );
endinterface

// File: rtl/eth_latency_timer.sv
// eth_latency_timer: measures main->loop (ping) and loop->main (pong) latency of a
// probe frame and stores {pong, ping} records in a first-word-fall-through FIFO.
// Optional feature: ETH_LATENCY_TIMER_DROP_COUNT_EN adds a saturating count of
// records lost to FIFO overflow.
module eth_latency_timer #(
  parameter int TIMER_WIDTH   = 32,
  parameter int FIFO_DEPTH    = 16,
  parameter int OVERFLOW_MODE = 0
) (
  input logic               clk,
  input logic               rst_n,
  eth_latency_timer_if.slave bus
);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_LOOP = 2'd1;
  localparam logic [1:0] WAIT_MAIN = 2'd2;

  // All-ones marks a timeout, so measured values stop one below it.
  localparam logic [TIMER_WIDTH-1:0] TIMER_MAX  = {{(TIMER_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [TIMER_WIDTH-1:0] TIMEOUT    = '1;
  localparam logic [TIMER_WIDTH-1:0] TIMER_INIT = TIMER_WIDTH'(2);
  localparam logic [LEVEL_W-1:0]     FULL_LEVEL = LEVEL_W'(FIFO_DEPTH);
  localparam bit                     DROP_OLD   = (OVERFLOW_MODE == 0);

  logic [1:0]               state;
  logic [TIMER_WIDTH-1:0]   timer;
  logic [TIMER_WIDTH-1:0]   ping;
  logic [TIMER_WIDTH-1:0]   pong;
  logic                     wr_pending;
  logic [2*TIMER_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [LEVEL_W-1:0]       level;

  logic tx_begin;
  logic pop;
  logic full;
  logic do_store;
  logic adv_rd;

  assign tx_begin = bus.main_tx_begin | bus.loop_tx_begin;
  assign pop      = bus.fifo_read & (level != '0);
  assign full     = (level == FULL_LEVEL);
  // A record is stored when there is room, when the same-edge pop frees a slot,
  // or when drop-oldest overwrites the head slot.
  assign do_store = wr_pending & (~full | pop | DROP_OLD);
  // The read side advances on a pop or when drop-oldest discards the head.
  assign adv_rd   = pop | (wr_pending & full & DROP_OLD);

  // Measurement FSM and free-running saturating timer; a finished measurement
  // raises wr_pending so the record lands in the FIFO one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      ping       <= '0;
      pong       <= '0;
      wr_pending <= 1'b0;
    end else begin
      wr_pending <= 1'b0;
      if (tx_begin) begin
        timer <= TIMER_INIT;
      end else if (timer != TIMER_MAX) begin
        timer <= timer + 1'b1;
      end
      if (tx_begin) begin
        ping  <= '0;
        pong  <= '0;
        state <= WAIT_LOOP;
      end else if (state == WAIT_LOOP && bus.loop_rx_end) begin
        ping  <= timer;
        state <= WAIT_MAIN;
      end else if (state == WAIT_LOOP && bus.loop_rx_timeout) begin
        ping       <= TIMEOUT;
        pong       <= TIMEOUT;
        wr_pending <= 1'b1;
        state      <= IDLE;
      end else if (state == WAIT_MAIN && bus.main_rx_end) begin
        pong       <= timer;
        wr_pending <= 1'b1;
        state      <= IDLE;
      end else if (state == WAIT_MAIN && bus.main_rx_timeout) begin
        pong       <= TIMEOUT;
        wr_pending <= 1'b1;
        state      <= IDLE;
      end
    end
  end

  // FIFO pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_store) wr_ptr <= wr_ptr + 1'b1;
      if (adv_rd)   rd_ptr <= rd_ptr + 1'b1;
      if (do_store && !adv_rd) begin
        level <= level + 1'b1;
      end else if (adv_rd && !do_store) begin
        level <= level - 1'b1;
      end
    end
  end

  // Record storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_store) mem[wr_ptr] <= {pong, ping};
  end

`ifdef ETH_LATENCY_TIMER_DROP_COUNT_EN
  logic [31:0] drop_count;
  logic        drop;

  assign drop = wr_pending & full & ~pop;

  // Saturating count of records lost to overflow under either policy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (drop && drop_count != 32'hFFFF_FFFF) begin
      drop_count <= drop_count + 32'd1;
    end
  end

  assign bus.drop_count = drop_count;
`endif

  assign bus.fifo_out   = mem[rd_ptr];
  assign bus.fifo_empty = (level == '0);
  assign bus.fifo_level = level;
  assign bus.fsm_state  = state;
endmodule

// File: tb/tb_eth_latency_timer.sv
// tb_eth_latency_timer: two DUTs (drop-oldest and drop-newest) share one stimulus
// stream; each has a reference model feeding an expected-record queue and a monitor.
// Optional feature checked when defined: ETH_LATENCY_TIMER_DROP_COUNT_EN.
module tb_eth_latency_timer;
  localparam int TW      = 8;
  localparam int DEPTH   = 4;
  localparam int LW      = $clog2(DEPTH + 1);
  localparam longint MAXV = (longint'(1) << TW) - 2;

  localparam logic [5:0] EV_MTX = 6'b000001;
  localparam logic [5:0] EV_MRE = 6'b000010;
  localparam logic [5:0] EV_MTO = 6'b000100;
  localparam logic [5:0] EV_LTX = 6'b001000;
  localparam logic [5:0] EV_LRE = 6'b010000;
  localparam logic [5:0] EV_LTO = 6'b100000;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic main_tx_begin = 1'b0, main_rx_end = 1'b0, main_rx_timeout = 1'b0;
  logic loop_tx_begin = 1'b0, loop_rx_end = 1'b0, loop_rx_timeout = 1'b0;
  logic fifo_read = 1'b0;

  logic [2*TW-1:0] out_w   [2];
  logic            empty_w [2];
  logic [LW-1:0]   level_w [2];
`ifdef ETH_LATENCY_TIMER_DROP_COUNT_EN
  logic [31:0]     drop_w  [2];
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- DUTs, models, monitors ----------------
  for (genvar m = 0; m < 2; m++) begin : g_inst
    eth_latency_timer_if #(.TIMER_WIDTH(TW), .FIFO_DEPTH(DEPTH)) bus ();

    assign bus.main_tx_begin   = main_tx_begin;
    assign bus.main_rx_end     = main_rx_end;
    assign bus.main_rx_timeout = main_rx_timeout;
    assign bus.loop_tx_begin   = loop_tx_begin;
    assign bus.loop_rx_end     = loop_rx_end;
    assign bus.loop_rx_timeout = loop_rx_timeout;
    assign bus.fifo_read       = fifo_read;
    assign out_w[m]   = bus.fifo_out;
    assign empty_w[m] = bus.fifo_empty;
    assign level_w[m] = bus.fifo_level;
`ifdef ETH_LATENCY_TIMER_DROP_COUNT_EN
    assign drop_w[m]  = bus.drop_count;
`endif

    eth_latency_timer #(.TIMER_WIDTH(TW), .FIFO_DEPTH(DEPTH), .OVERFLOW_MODE(m)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
    );

    // Reference model: latency = edges since probe start, expected FIFO as a queue.
    logic [2*TW-1:0] exp_q[$];
    int              phase = 0;     // 0 none, 1 awaiting loop, 2 awaiting main
    longint          cyc = 0;
    longint          start = 0;
    longint          lat;
    bit              pend = 0;
    bit              pop;
    logic [2*TW-1:0] pend_rec;
    logic [TW-1:0]   m_ping = '0;
    int              drops = 0;

    initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        phase = 0;
        pend  = 0;
        start = cyc;
        drops = 0;
      end else begin
        lat = cyc - start;
        if (lat > MAXV) lat = MAXV;
        pop = fifo_read && exp_q.size() != 0;
        if (pend) begin
          if (pop) begin
            void'(exp_q.pop_front());
            exp_q.push_back(pend_rec);
          end else if (exp_q.size() < DEPTH) begin
            exp_q.push_back(pend_rec);
          end else begin
            drops++;
            if (m == 0) begin
              void'(exp_q.pop_front());
              exp_q.push_back(pend_rec);
            end
          end
        end else if (pop) begin
          void'(exp_q.pop_front());
        end
        pend = 0;
        if (main_tx_begin || loop_tx_begin) begin
          phase = 1;
          start = cyc - 1;
        end else if (phase == 1 && loop_rx_end) begin
          m_ping = lat[TW-1:0];
          phase  = 2;
        end else if (phase == 1 && loop_rx_timeout) begin
          pend = 1; pend_rec = '1; phase = 0;
        end else if (phase == 2 && main_rx_end) begin
          pend = 1; pend_rec = {lat[TW-1:0], m_ping}; phase = 0;
        end else if (phase == 2 && main_rx_timeout) begin
          pend = 1; pend_rec = {{TW{1'b1}}, m_ping}; phase = 0;
        end
        cyc++;
      end
    end

    // Monitor: compares the presented head record and occupancy after every edge.
    initial forever begin
      @(negedge clk);
      chk($sformatf("i%0d_empty", m), 64'(bus.fifo_empty), 64'(exp_q.size() == 0));
      chk($sformatf("i%0d_level", m), 64'(bus.fifo_level), 64'(exp_q.size()));
      if (exp_q.size() != 0) chk($sformatf("i%0d_head", m), 64'(bus.fifo_out), 64'(exp_q[0]));
`ifdef ETH_LATENCY_TIMER_DROP_COUNT_EN
      chk($sformatf("i%0d_drop", m), 64'(bus.drop_count), 64'(drops));
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic [5:0] ev, input logic rd);
    {loop_rx_timeout, loop_rx_end, loop_tx_begin, main_rx_timeout, main_rx_end, main_tx_begin} = ev;
    fifo_read = rd;
    @(posedge clk); #1;
    {loop_rx_timeout, loop_rx_end, loop_tx_begin, main_rx_timeout, main_rx_end, main_tx_begin} = '0;
    fifo_read = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) cyc('0, 1'b1);
  endtask

  // Record {gap+3, gap+2}: probe start, gap idle edges, loop end, main end.
  task automatic make_rec(input int gap);
    cyc(EV_MTX, 1'b0);
    idle(gap);
    cyc(EV_LRE, 1'b0);
    cyc(EV_MRE, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0] ev;
    int         r;
`ifdef ETH_LATENCY_TIMER_DROP_COUNT_EN
    logic [31:0] d0, d1;
`endif
    #1 rst_n = 1'b0;
    #2;
    for (int k = 0; k < 2; k++) begin
      chk("rst_empty", 64'(empty_w[k]), 64'd1);
      chk("rst_level", 64'(level_w[k]), 64'd0);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic measurement: ping 11, pong 26, visible one edge after main end.
    cyc(EV_MTX, 1'b0);
    idle(9);
    cyc(EV_LRE, 1'b0);
    idle(14);
    cyc(EV_MRE, 1'b0);
    chk("basic_not_yet", 64'(empty_w[0]), 64'd1);
    cyc('0, 1'b0);
    chk("basic_empty", 64'(empty_w[0]), 64'd0);
    chk("basic_rec", 64'(out_w[0]), 64'h1A0B);
    drain();

    // Loop timeout gives all-ones; main end in IDLE adds nothing.
    cyc(EV_MTX, 1'b0);
    idle(4);
    cyc(EV_LTO, 1'b0);
    cyc('0, 1'b0);
    chk("tmo_rec", 64'(out_w[0]), 64'hFFFF);
    cyc(EV_MRE, 1'b0);
    idle(2);
    chk("tmo_level", 64'(level_w[0]), 64'd1);
    drain();

    // Timer saturation one below all-ones.
    cyc(EV_MTX, 1'b0);
    idle(300);
    cyc(EV_LRE, 1'b0);
    cyc(EV_MRE, 1'b0);
    cyc('0, 1'b0);
    chk("sat_rec", 64'(out_w[1]), 64'hFEFE);
    drain();

    // Overflow: six records, no reads.
`ifdef ETH_LATENCY_TIMER_DROP_COUNT_EN
    d0 = drop_w[0]; d1 = drop_w[1];
`endif
    for (int k = 1; k <= 6; k++) make_rec(k);
    cyc('0, 1'b0);
    chk("ovf_level0", 64'(level_w[0]), 64'd4);
    chk("ovf_level1", 64'(level_w[1]), 64'd4);
`ifdef ETH_LATENCY_TIMER_DROP_COUNT_EN
    chk("ovf_drop0", 64'(drop_w[0] - d0), 64'd2);
    chk("ovf_drop1", 64'(drop_w[1] - d1), 64'd2);
`endif
    for (int j = 0; j < 4; j++) begin
      chk("ovf_old_order", 64'(out_w[0]), 64'({TW'(j + 6), TW'(j + 5)}));
      chk("ovf_new_order", 64'(out_w[1]), 64'({TW'(j + 4), TW'(j + 3)}));
      cyc('0, 1'b1);
    end

    // Full FIFO with write and pop on the same edge: level holds, no drop.
    for (int k = 1; k <= 4; k++) make_rec(k);
    cyc('0, 1'b0);
`ifdef ETH_LATENCY_TIMER_DROP_COUNT_EN
    d0 = drop_w[0]; d1 = drop_w[1];
`endif
    make_rec(9);
    cyc('0, 1'b1);
    chk("wr_rd_level0", 64'(level_w[0]), 64'd4);
    chk("wr_rd_level1", 64'(level_w[1]), 64'd4);
`ifdef ETH_LATENCY_TIMER_DROP_COUNT_EN
    chk("wr_rd_drop0", 64'(drop_w[0] - d0), 64'd0);
    chk("wr_rd_drop1", 64'(drop_w[1] - d1), 64'd0);
`endif

    // Reset in the middle of awaiting main end discards the measurement.
    cyc(EV_MTX, 1'b0);
    cyc(EV_LRE, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_level", 64'(level_w[0]), 64'd0);
    chk("mid_rst_empty", 64'(empty_w[1]), 64'd1);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    cyc(EV_MRE, 1'b0);
    idle(2);
    chk("mid_rst_norec0", 64'(empty_w[0]), 64'd1);
    chk("mid_rst_norec1", 64'(empty_w[1]), 64'd1);

    // Randomized traffic against the models.
    for (int i = 0; i < 3000; i++) begin
      ev = '0;
      r  = $urandom_range(0, 99);
      if (r < 5) ev |= ($urandom_range(0, 1) != 0) ? EV_MTX : EV_LTX;
      if ($urandom_range(0, 1) != 0) begin
        if ($urandom_range(0, 99) < 15) ev |= EV_LRE;
        if ($urandom_range(0, 99) < 5)  ev |= EV_LTO;
      end else begin
        if ($urandom_range(0, 99) < 15) ev |= EV_MRE;
        if ($urandom_range(0, 99) < 5)  ev |= EV_MTO;
      end
      cyc(ev, $urandom_range(0, 99) < 20);
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
